gray_matrix_3x3: RTL and testbench
==================================

# gray_matrix_3x3

Synthesizable 3×3 neighbourhood generator for 8-bit grayscale video. Sits directly downstream of the simulation BMP video-stream source and upstream of every window-based filter (mean, median, Sobel, erosion/dilation). Consumes the vsync/hsync/valid/data stream, buffers the two previous lines in on-chip RAM and emits a registered 3×3 pixel window plus delayed sync and valid signals, with fixed latency.

## Interface
- `DATA_W`, 8, pixel width in bits.
- `MAX_WIDTH`, 2048, line-buffer depth; the widest supported active line in pixels.
- `XW`, `$clog2(MAX_WIDTH)`, column counter width (derived; do not override).

- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `vin_vsync`  in  1  frame sync, active high.
- `vin_hsync`  in  1  line sync, active high.
- `vin_valid`  in  1  active-pixel qualifier.
- `vin_dat`  in  DATA_W  pixel; sampled only when `vin_valid`=1.
- `vout_vsync`  out  1  `vin_vsync` delayed 2 clk.
- `vout_hsync`  out  1  `vin_hsync` delayed 2 clk.
- `vout_valid`  out  1  `vin_valid` delayed 2 clk.
- `m11,m12,m13`  out  DATA_W each  window top row (line y-2), columns x-2, x-1, x.
- `m21,m22,m23`  out  DATA_W each  middle row (line y-1).
- `m31,m32,m33`  out  DATA_W each  bottom row (line y, current pixel = `m33`).

## Operation
- Column counter `x` (XW+1 bits): cleared when `vin_valid`=0; increments per valid pixel; saturates at MAX_WIDTH.
- Row counter `y` (2 bits, saturating at 2): cleared on the `vin_vsync` rising edge; increments on each `vin_valid` falling edge (end of line).
- Line buffers LB1 (line y-1) and LB2 (line y-2): simple dual-port RAMs, MAX_WIDTH × DATA_W, 1-cycle synchronous read, no reset on contents.
- For each valid pixel at `x` < MAX_WIDTH: read LB1[x], LB2[x] in cycle t. In cycle t+1, write LB1[x] ← pixel and LB2[x] ← old LB1[x] (read-before-write on the same address).
- Vertical masking: if `y`=0, the top and middle row taps are forced to 0. If `y`=1, the top row tap is forced to 0. For `x` ≥ MAX_WIDTH, all upper-row taps are forced to 0 and RAM writes are suppressed.
- Horizontal window: three 3-stage shift registers, one per row, shifting only on delayed-valid.
  - Shift registers are cleared when the delayed valid is 0, so columns x-1 and x-2 left of the image read 0.
- Zero padding is the only edge mode. Downstream filters own border policy.
- Output count equals input count: every input valid pixel yields exactly one output valid cycle. Frame geometry is unchanged.
- Reset mid-frame clears counters, pipelines, window and outputs. The following lines are treated as lines 0, 1, ... until the next vsync edge re-aligns. RAM contents are don't-care because masking covers them.

## Timing
- Reset: all outputs 0; `x`=0, `y`=0, delay pipes 0.
- Latency is 2 clk. A pixel sampled at edge t appears as `m33` with `vout_valid`=1 after edge t+2.
  - Stage 1 (t+1): registered pixel, registered `x`/`y` masks, RAM read data available.
  - Stage 2 (t+2): window shift and output registers.
- `vout_vsync`/`vout_hsync`/`vout_valid` use the same 2-stage delay, so they stay exactly aligned with the window.
- Window outputs hold their last value while `vout_valid`=0 (no shift). Consumers qualify with `vout_valid`.
- Back-to-back lines with a single invalid cycle between them are supported. That one cycle clears `x` and the window and bumps `y`.
- A `vin_vsync` rising edge coinciding with `vin_valid`=1 is a protocol error; `y` clears and the pixel is processed as line 0.
- Throughput: 1 pixel/clk sustained, with no stall or back-pressure.

## Test plan
- Reset: hold `rst_n`=0 for 5 clk with random inputs -> all outputs 0. Release -> outputs stay 0 until the first valid pixel.
- 8×6 ramp frame from the BMP stream source, pixel(x,y)=16·y+x:
  - at line y=3, x=4, `vout_valid`=1 with m11..m13=18,19,20, m21..m23=34,35,36, m31..m33=50,51,52;
  - exactly 48 output valid cycles.
- Top-left border: same frame, first output pixel (0,0) -> m33=0, all other taps 0. Pixel (1,1) -> m22=0, m23=1, m32=16, m33=17, top row 0.
- Latency/alignment: single-valid-pulse lines -> `vout_valid`, `vout_hsync` and `vout_vsync` edges are exactly 2 clk after the input edges in every case.
- Mid-frame reset at line 3, then resume without vsync -> the first post-reset line has top and middle rows 0, and the second has top row 0. After the next vsync, frame output matches the golden ramp.
- Two consecutive frames of different content (ramp, then constant 0xA5) -> frame-2 line 0 upper rows are 0, with no frame-1 data leaking. Line 2 shows 0xA5 in all nine taps for x ≥ 2.

Source files
------------

// File: rtl/gray_matrix_3x3.sv
// ---------------------------------------------------------------------------
// gray_matrix_3x3
//
// 3x3 neighbourhood generator for an 8-bit grayscale video stream. The block
// keeps the two previous lines in on-chip line buffers. For every input pixel
// it presents the 3x3 window that ends at that pixel. Borders are zero-padded:
// rows above the top of the frame and columns left of the line start read 0.
//
// Latency is two clocks. A pixel presented on vin_* is registered into
// stage 1 on the next edge. It reaches m33 with vout_valid=1 on the edge
// after that. vout_vsync, vout_hsync and vout_valid pass through the same two
// stages, so they stay aligned with the window.
//
// Parameters
//   DATA_W    pixel width in bits
//   MAX_WIDTH line-buffer depth (widest supported active line, in pixels)
//   XW        column address width, derived from MAX_WIDTH (do not override)
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous, active-low reset
//   vin_vsync    frame sync, active high
//   vin_hsync    line sync, active high
//   vin_valid    active-pixel qualifier
//   vin_dat      pixel, sampled only when vin_valid=1
//   vout_vsync   vin_vsync delayed 2 clk
//   vout_hsync   vin_hsync delayed 2 clk
//   vout_valid   vin_valid delayed 2 clk
//   m11..m13     top row    (line y-2), columns x-2, x-1, x
//   m21..m23     middle row (line y-1), columns x-2, x-1, x
//   m31..m33     bottom row (line y),   columns x-2, x-1, x (m33 = current)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// gray_matrix_3x3_lb
//
// Simple dual-port line buffer with one write port and one read port. The
// read is synchronous with one cycle of latency. A read and a write to the
// same address on the same edge return the old contents.
//
// Ports
//   clk     clock
//   we      write enable
//   waddr   write address
//   wdata   write data
//   raddr   read address
//   rdata   registered read data
// ---------------------------------------------------------------------------
module gray_matrix_3x3_lb #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset. That lets it map onto block RAM.
    // Stale contents never reach the outputs because the row masks zero
    // every tap that has not been written in the current frame.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

module gray_matrix_3x3 #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 2048,
    parameter int XW        = $clog2(MAX_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vin_vsync,
    input  logic              vin_hsync,
    input  logic              vin_valid,
    input  logic [DATA_W-1:0] vin_dat,
    output logic              vout_vsync,
    output logic              vout_hsync,
    output logic              vout_valid,
    output logic [DATA_W-1:0] m11,
    output logic [DATA_W-1:0] m12,
    output logic [DATA_W-1:0] m13,
    output logic [DATA_W-1:0] m21,
    output logic [DATA_W-1:0] m22,
    output logic [DATA_W-1:0] m23,
    output logic [DATA_W-1:0] m31,
    output logic [DATA_W-1:0] m32,
    output logic [DATA_W-1:0] m33
);

    // The column counter has one extra bit so it can hold MAX_WIDTH itself.
    // That value marks pixels beyond the line-buffer depth.
    localparam logic [XW:0] X_LIMIT = (XW+1)'(MAX_WIDTH);
    localparam logic [XW:0] X_ONE   = (XW+1)'(1);

    // -----------------------------------------------------------------------
    // Input-side counters and edge detectors
    // -----------------------------------------------------------------------
    logic [XW:0] x;          // column of the pixel on vin_dat
    logic [1:0]  y;          // line index in the frame, saturates at 2
    logic        vsync_q;    // previous vin_vsync, for rising-edge detection
    logic        valid_q;    // previous vin_valid, for end-of-line detection

    logic        vs_rise;
    logic        valid_fall;
    logic [1:0]  y_line;     // line index that applies to the current pixel
    logic        x_in_range;

    // A vsync rising edge that arrives together with a valid pixel puts that
    // pixel on line 0, so the mask uses the cleared index straight away.
    assign vs_rise    = vin_vsync & ~vsync_q;
    assign valid_fall = valid_q & ~vin_valid;
    assign y_line     = vs_rise ? 2'd0 : y;
    assign x_in_range = (x < X_LIMIT);

    // NOTE: state registers use non-blocking assignments only. Every
    // register then updates from pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            vsync_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            vsync_q <= vin_vsync;
            valid_q <= vin_valid;

            if (!vin_valid) begin
                x <= '0;
            end else if (x_in_range) begin
                x <= x + X_ONE;
            end

            if (vs_rise) begin
                y <= 2'd0;
            end else if (valid_fall && (y != 2'd2)) begin
                y <= y + 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: registered pixel, row masks and write command
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] pix_d1;
    logic              valid_d1;
    logic              vsync_d1;
    logic              hsync_d1;
    logic              top_en_d1;   // top row (line y-2) may be shown
    logic              mid_en_d1;   // middle row (line y-1) may be shown
    logic              wr_en_d1;
    logic [XW-1:0]     wr_addr_d1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_d1     <= '0;
            valid_d1   <= 1'b0;
            vsync_d1   <= 1'b0;
            hsync_d1   <= 1'b0;
            top_en_d1  <= 1'b0;
            mid_en_d1  <= 1'b0;
            wr_en_d1   <= 1'b0;
            wr_addr_d1 <= '0;
        end else begin
            pix_d1     <= vin_dat;
            valid_d1   <= vin_valid;
            vsync_d1   <= vin_vsync;
            hsync_d1   <= vin_hsync;
            top_en_d1  <= (y_line == 2'd2) && x_in_range;
            mid_en_d1  <= (y_line != 2'd0) && x_in_range;
            wr_en_d1   <= vin_valid && x_in_range;
            wr_addr_d1 <= x[XW-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Line buffers. Both are read at the column of the incoming pixel. One
    // cycle later, that column is written: LB1 takes the new pixel and LB2
    // takes the line LB1 held. This moves each line down one buffer per line.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] lb1_q;   // line y-1 at this column
    logic [DATA_W-1:0] lb2_q;   // line y-2 at this column

    gray_matrix_3x3_lb #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_WIDTH),
        .AW     (XW)
    ) u_lb1 (
        .clk    (clk),
        .we     (wr_en_d1),
        .waddr  (wr_addr_d1),
        .wdata  (pix_d1),
        .raddr  (x[XW-1:0]),
        .rdata  (lb1_q)
    );

    gray_matrix_3x3_lb #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_WIDTH),
        .AW     (XW)
    ) u_lb2 (
        .clk    (clk),
        .we     (wr_en_d1),
        .waddr  (wr_addr_d1),
        .wdata  (lb1_q),
        .raddr  (x[XW-1:0]),
        .rdata  (lb2_q)
    );

    // -----------------------------------------------------------------------
    // Masked column taps entering the window
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] top_tap;
    logic [DATA_W-1:0] mid_tap;

    // NOTE: each combinational output gets a default assignment first. Then
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        top_tap = '0;
        mid_tap = '0;
        if (top_en_d1) begin
            top_tap = lb2_q;
        end
        if (mid_en_d1) begin
            mid_tap = lb1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: horizontal window
    //
    // The *_h1/*_h2 registers hold the taps of columns x-1 and x-2 of the
    // current line. They clear on any invalid cycle, so a new line starts
    // with zero padding on its left. The m* outputs load only on valid
    // cycles. They hold the last window between lines and hold zero after
    // reset.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] top_h1, top_h2;
    logic [DATA_W-1:0] mid_h1, mid_h2;
    logic [DATA_W-1:0] bot_h1, bot_h2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_h1     <= '0;
            top_h2     <= '0;
            mid_h1     <= '0;
            mid_h2     <= '0;
            bot_h1     <= '0;
            bot_h2     <= '0;
            m11        <= '0;
            m12        <= '0;
            m13        <= '0;
            m21        <= '0;
            m22        <= '0;
            m23        <= '0;
            m31        <= '0;
            m32        <= '0;
            m33        <= '0;
            vout_vsync <= 1'b0;
            vout_hsync <= 1'b0;
            vout_valid <= 1'b0;
        end else begin
            vout_vsync <= vsync_d1;
            vout_hsync <= hsync_d1;
            vout_valid <= valid_d1;

            if (valid_d1) begin
                m11    <= top_h2;
                m12    <= top_h1;
                m13    <= top_tap;
                m21    <= mid_h2;
                m22    <= mid_h1;
                m23    <= mid_tap;
                m31    <= bot_h2;
                m32    <= bot_h1;
                m33    <= pix_d1;

                top_h2 <= top_h1;
                top_h1 <= top_tap;
                mid_h2 <= mid_h1;
                mid_h1 <= mid_tap;
                bot_h2 <= bot_h1;
                bot_h1 <= pix_d1;
            end else begin
                top_h1 <= '0;
                top_h2 <= '0;
                mid_h1 <= '0;
                mid_h2 <= '0;
                bot_h1 <= '0;
                bot_h2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gray_matrix_3x3.sv
// ---------------------------------------------------------------------------
// tb_gray_matrix_3x3
//
// Self-checking bench for gray_matrix_3x3. A driver sends frames of ramp,
// constant or random pixels. For every valid pixel, a frame-level model keeps
// the current and the two previous lines as plain arrays. From these it
// pushes the expected 3x3 window into a queue. A monitor runs on the falling
// edge. It checks the sync/valid outputs against the inputs seen two edges
// earlier. It pops and compares a window on every vout_valid cycle. It also
// checks that the window holds on idle cycles.
// ---------------------------------------------------------------------------
module tb_gray_matrix_3x3;

    localparam int DW    = 8;
    localparam int MAXW  = 16;   // small depth so the beyond-depth case is reachable
    localparam int LMAX  = 64;   // model line storage

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vin_vsync = 1'b0;
    logic          vin_hsync = 1'b0;
    logic          vin_valid = 1'b0;
    logic [DW-1:0] vin_dat = '0;
    logic          vout_vsync, vout_hsync, vout_valid;
    logic [DW-1:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;

    gray_matrix_3x3 #(
        .DATA_W    (DW),
        .MAX_WIDTH (MAXW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vin_vsync  (vin_vsync),
        .vin_hsync  (vin_hsync),
        .vin_valid  (vin_valid),
        .vin_dat    (vin_dat),
        .vout_vsync (vout_vsync),
        .vout_hsync (vout_hsync),
        .vout_valid (vout_valid),
        .m11 (m11), .m12 (m12), .m13 (m13),
        .m21 (m21), .m22 (m22), .m23 (m23),
        .m31 (m31), .m32 (m32), .m33 (m33)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Check bookkeeping
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Frame-level reference model
    // -----------------------------------------------------------------------
    logic [DW-1:0] cur_line [LMAX];
    logic [DW-1:0] prev1    [LMAX];
    logic [DW-1:0] prev2    [LMAX];
    int            line_no  = 0;     // line index within the frame (2 means "2 or more")
    int            col      = 0;
    logic          m_vs_prev = 1'b0;
    logic          m_v_prev  = 1'b0;
    logic [71:0]   exp_q [$];

    function automatic logic [DW-1:0] tap(input int row, input int c);
        if (c < 0) return '0;
        case (row)
            0:       return (line_no >= 2 && c < MAXW) ? prev2[c] : '0;
            1:       return (line_no >= 1 && c < MAXW) ? prev1[c] : '0;
            default: return cur_line[c];
        endcase
    endfunction

    task automatic model_reset();
        line_no   = 0;
        col       = 0;
        m_vs_prev = 1'b0;
        m_v_prev  = 1'b0;
    endtask

    task automatic model_step(input logic vs, input logic v, input logic [DW-1:0] d);
        logic vs_rise;
        vs_rise = vs && !m_vs_prev;
        if (vs_rise) line_no = 0;
        if (v) begin
            cur_line[col] = d;
            exp_q.push_back({tap(0, col-2), tap(0, col-1), tap(0, col),
                             tap(1, col-2), tap(1, col-1), tap(1, col),
                             tap(2, col-2), tap(2, col-1), tap(2, col)});
            if (col < LMAX-1) col++;
        end else begin
            if (m_v_prev) begin
                prev2 = prev1;
                prev1 = cur_line;
                if (!vs_rise && line_no < 2) line_no++;
            end
            col = 0;
        end
        m_vs_prev = vs;
        m_v_prev  = v;
    endtask

    // -----------------------------------------------------------------------
    // Driver helpers
    // -----------------------------------------------------------------------
    task automatic drive(input logic vs, input logic hs, input logic v, input logic [DW-1:0] d);
        @(posedge clk); #1;
        vin_vsync = vs;
        vin_hsync = hs;
        vin_valid = v;
        vin_dat   = d;
        if (rst_n) model_step(vs, v, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic apply_reset(input int n, input bit random_inputs);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst_n     = 1'b0;
            vin_vsync = random_inputs ? 1'($urandom) : 1'b0;
            vin_hsync = random_inputs ? 1'($urandom) : 1'b0;
            vin_valid = random_inputs ? 1'($urandom) : 1'b0;
            vin_dat   = random_inputs ? DW'($urandom) : '0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        vin_vsync = 1'b0;
        vin_hsync = 1'b0;
        vin_valid = 1'b0;
        vin_dat   = '0;
        model_step(1'b0, 1'b0, '0);
    endtask

    // kind: 0 = ramp 16*y+x, 1 = constant 0xA5, 2 = random
    function automatic logic [DW-1:0] pixel(input int kind, input int px, input int py);
        case (kind)
            0:       return DW'(16*py + px);
            1:       return 8'hA5;
            default: return DW'($urandom);
        endcase
    endfunction

    // Each line is followed by 'gap' invalid cycles. hsync pulses on the
    // first of them, so gap=1 gives back-to-back lines.
    task automatic frame(input int w, input int h, input int kind, input int gap, input bit with_vsync);
        if (with_vsync) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            drive(1'b1, 1'b0, 1'b0, '0);
            idle(2);
        end
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) drive(1'b0, 1'b0, 1'b1, pixel(kind, px, py));
            for (int g = 0; g < gap; g++) drive(1'b0, (g == 0), 1'b0, '0);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: sync delay check, window scoreboard, hold check
    // -----------------------------------------------------------------------
    logic [2:0]  sync_p1 = '0, sync_p2 = '0;
    logic [71:0] last_win = '0;
    int          out_cnt  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p1 <= {vin_vsync, vin_hsync, vin_valid};
            sync_p2 <= sync_p1;
        end
    end

    always @(negedge clk) begin
        logic [71:0] win;
        logic [71:0] e;
        win = {m11, m12, m13, m21, m22, m23, m31, m32, m33};
        if (!rst_n) begin
            last_win = '0;
        end else begin
            check("sync_delay", {69'd0, vout_vsync, vout_hsync, vout_valid}, {69'd0, sync_p2});
            if (vout_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL window_unexpected at %0t: got %h, expected no output", $time, win);
                end else begin
                    e = exp_q.pop_front();
                    check("window", win, e);
                    last_win = e;
                end
            end else begin
                check("window_hold", win, last_win);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int cnt0;

        // Reset with random inputs: all outputs must be 0.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vin_vsync = 1'($urandom);
            vin_hsync = 1'($urandom);
            vin_valid = 1'($urandom);
            vin_dat   = DW'($urandom);
        end
        @(negedge clk);
        check("reset_outputs",
              {60'd0, vout_vsync, vout_hsync, vout_valid, 9'd0} | {m11, m12, m13, m21, m22, m23, m31, m32, m33},
              72'd0);
        apply_reset(0, 1'b0);
        idle(3);
        @(negedge clk);
        check("post_reset_idle",
              {60'd0, vout_vsync, vout_hsync, vout_valid, 9'd0} | {m11, m12, m13, m21, m22, m23, m31, m32, m33},
              72'd0);

        // 8x6 ramp frame: exactly 48 output pixels.
        cnt0 = out_cnt;
        frame(8, 6, 0, 2, 1'b1);
        idle(4);
        check("ramp_output_count", 72'(out_cnt - cnt0), 72'd48);

        // Single-pixel lines for latency and alignment.
        frame(1, 4, 2, 3, 1'b1);
        idle(3);

        // Back-to-back lines with a single invalid cycle between them.
        frame(12, 5, 2, 1, 1'b1);
        idle(3);

        // Mid-frame reset at line 3, resume without vsync, then a full frame.
        frame(8, 3, 0, 2, 1'b1);
        for (int px = 0; px < 4; px++) drive(1'b0, 1'b0, 1'b1, pixel(0, px, 3));
        idle(3);
        apply_reset(2, 1'b0);
        frame(8, 3, 0, 2, 1'b0);
        frame(8, 6, 0, 2, 1'b1);
        idle(3);

        // Ramp frame followed by a constant 0xA5 frame.
        frame(8, 6, 0, 2, 1'b1);
        frame(8, 6, 1, 2, 1'b1);
        idle(3);

        // Lines wider than the line buffer depth.
        frame(20, 4, 2, 1, 1'b1);
        idle(3);

        // vsync rising edge together with a valid pixel.
        frame(6, 3, 2, 2, 1'b0);
        drive(1'b1, 1'b0, 1'b1, DW'($urandom));
        drive(1'b1, 1'b0, 1'b1, DW'($urandom));
        for (int px = 2; px < 6; px++) drive(1'b0, 1'b0, 1'b1, DW'($urandom));
        idle(2);
        frame(6, 2, 2, 2, 1'b0);
        idle(5);

        check("queue_drained", 72'(exp_q.size()), 72'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
